// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with programmable latency and valid/ready request/response handshakes
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   req_valid   initiator presents a request
//   req_ready   high only in IDLE
//   req_write   1 = store, 0 = load
//   req_addr    byte address, must be word aligned
//   req_wdata   store data
//   resp_valid  response available (RESP state)
//   resp_ready  initiator consumes the response
//   resp_rdata  load data; 0 for stores and errors
//   resp_err    misaligned or out-of-range request
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic [31:0] mem [DEPTH];
  logic [29:0] word;
  logic        bad;
  assign word       = addr[31:2];
  assign bad        = (addr[1:0] != 2'b00) || (word >= 30'(DEPTH));
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // Reset drops any in-flight transaction before its store can land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      wdata      <= '0;
      write      <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr  <= req_addr;
          wdata <= req_wdata;
          write <= req_write;
          cnt   <= 4'(LATENCY);
          state <= WAIT;
        end
        WAIT: if (cnt != 0) cnt <= cnt - 4'd1;
        else begin
          resp_err   <= bad;
          resp_rdata <= (bad || write) ? 32'd0 : mem[word[AW-1:0]];
          if (!bad && write) mem[word[AW-1:0]] <= wdata;
          state <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven check of data_mem_responder with LATENCY=2 and LATENCY=0 instances
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        rdy2, vld2, err2, rdy0, vld0, err0;
  logic [31:0] rd2, rd0;
  logic        rdy, vld, err;
  logic [31:0] rdata;
  int          total = 0;
  int          passed = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH(64), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(err2)
  );
  data_mem_responder #(.DEPTH(64), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(err0)
  );
  assign rdy   = sel ? rdy0 : rdy2;
  assign vld   = sel ? vld0 : vld2;
  assign err   = sel ? err0 : err2;
  assign rdata = sel ? rd0 : rd2;
  typedef struct {
    string       name;
    logic        dut;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b1;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin total++; $display("FAIL accept timeout addr %h", a); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!vld && lat < 50) begin @(posedge clk); #1; lat++; end
    if (lat >= 50) begin total++; $display("FAIL response timeout addr %h", a); end
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;
    vecs.push_back('{"ld_0x10_after_reset", 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 3});
    vecs.push_back('{"st_0x08", 1'b0, 1'b1, 32'h08, 32'hAB, 32'h0, 1'b0, 3});
    vecs.push_back('{"ld_0x08", 1'b0, 1'b0, 32'h08, 32'h0, 32'hAB, 1'b0, 3});
    vecs.push_back('{"ld_misaligned_0x06", 1'b0, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 3});
    vecs.push_back('{"ld_oor_0x100", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 3});
    vecs.push_back('{"ld_0x00", 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 3});
    vecs.push_back('{"st_oor_0x100", 1'b0, 1'b1, 32'h100, 32'h77, 32'h0, 1'b1, 3});
    vecs.push_back('{"st_top_0xFC", 1'b0, 1'b1, 32'hFC, 32'hDEADBEEF, 32'h0, 1'b0, 3});
    vecs.push_back('{"ld_top_0xFC", 1'b0, 1'b0, 32'hFC, 32'h0, 32'hDEADBEEF, 1'b0, 3});
    vecs.push_back('{"ld_0x08_again", 1'b0, 1'b0, 32'h08, 32'h0, 32'hAB, 1'b0, 3});
    vecs.push_back('{"l0_st_0xFC", 1'b1, 1'b1, 32'hFC, 32'h55AA, 32'h0, 1'b0, 1});
    vecs.push_back('{"l0_ld_0xFC", 1'b1, 1'b0, 32'hFC, 32'h0, 32'h55AA, 1'b0, 1});
    vecs.push_back('{"l0_ld_0x100", 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{"l0_st_misaligned", 1'b1, 1'b1, 32'h02, 32'h99, 32'h0, 1'b1, 1});
    vecs.push_back('{"l0_ld_0x00", 1'b1, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 1});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, rdy2}, 32'd1);
    chk("reset_resp_valid", {31'd0, vld2}, 32'd0);
    chk("reset_resp_rdata", rd2, 32'd0);
    chk("reset_l0_req_ready", {31'd0, rdy0}, 32'd1);
    @(negedge clk) rst = 1'b1;
    foreach (vecs[i]) begin
      sel = vecs[i].dut;
      txn(vecs[i].w, vecs[i].a, vecs[i].d, rd, e, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_back_idle"}, {30'd0, vld, rdy}, 32'd1);
    end
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h08; resp_ready = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_addr = 32'hFC; req_write = 1'b1; req_wdata = 32'h1111;
    n = 0;
    while (!vld && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), {31'd0, vld}, 32'd1);
      chk($sformatf("bp_rdata_%0d", k), rdata, 32'hAB);
      chk($sformatf("bp_req_ready_%0d", k), {31'd0, rdy}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, vld}, 32'd0);
    chk("bp_release_rdata", rdata, 32'd0);
    chk("bp_release_ready", {31'd0, rdy}, 32'd1);
    txn(1'b0, 32'hFC, 32'h0, rd, e, lat);
    chk("bp_ignored_store_0xFC", rd, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h04; req_wdata = 32'h1234;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk) rst = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); n += int'(vld); end
    chk("rst_no_stray_valid", n, 0);
    txn(1'b0, 32'h04, 32'h0, rd, e, lat);
    chk("rst_dropped_store_0x04", rd, 32'd0);
    txn(1'b0, 32'h08, 32'h0, rd, e, lat);
    chk("rst_cleared_0x08", rd, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
